// File: rtl/palette_cycler.sv
// -----------------------------------------------------------------------------
// palette_cycler
//   A writable colour palette with hardware colour cycling. After reset the
//   palette loads a grey ramp, one entry per cycle, while busy is high. After
//   that the host may rewrite entries. Reads are indexed logically: the
//   physical entry is (rd_addr + offset) mod N. The offset rotates by one every
//   cycle_div+1 frame ticks while cycle_en is high.
//
// Ports
//   clk, rst            : clock; asynchronous active-high reset
//   wr_en/addr/data     : physical-entry write (ignored while loading)
//   rd_en/rd_addr       : logical-index read request (ignored while loading)
//   rd_data/rd_valid    : registered read result, one cycle after the request
//   frame_tick          : one-cycle pulse per video frame
//   cycle_en/dir/div    : rotation enable, direction (1 = decrement), divider
//   busy                : default-contents load in progress
//   offset              : current rotation offset
// -----------------------------------------------------------------------------
module palette_cycler #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  frame_tick,
  input  logic                  cycle_en,
  input  logic                  cycle_dir,
  input  logic [DIV_WIDTH-1:0]  cycle_div,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] offset
);

  localparam int N = 1 << ADDR_WIDTH;
  localparam int C = DATA_WIDTH / 3;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Each channel is the index bits repeated MSB-first until C bits are filled.
  // Extra bits are dropped. For 24/4 this gives entry i = 0xiiiiii.
  function automatic logic [DATA_WIDTH-1:0] default_entry(input logic [ADDR_WIDTH-1:0] idx);
    logic [C-1:0] ch;
    ch = '0;
    for (int b = 0; b < C; b++) begin
      ch[C-1-b] = idx[ADDR_WIDTH-1-(b % ADDR_WIDTH)];
    end
    return {ch, ch, ch};
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [ADDR_WIDTH-1:0] off_q, off_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH-1:0] mem_q [N];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] rd_phys;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    div_d      = div_q;
    off_d      = off_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    rd_valid_d = 1'b0;
    // The mod N wrap comes from the ADDR_WIDTH-bit sum. The read uses the
    // offset of the request cycle, so a rotating tick in this cycle has no effect.
    rd_phys    = rd_addr + off_q;

    unique case (state_q)
      ST_INIT: begin
        // Host reads, writes and ticks are dropped while the ramp loads.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = default_entry(ptr_q);
        ptr_d     = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we     = wr_en;
        rd_valid_d = rd_en;
        if (cycle_en && frame_tick) begin
          // The compare is >= so that lowering cycle_div below the current
          // count makes the next tick terminal and does not wait for a wrap.
          if (div_q >= cycle_div) begin
            div_d = '0;
            off_d = cycle_dir ? off_q - 1'b1 : off_q + 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All of them then
  // update together at the edge, whatever order they are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      div_q      <= '0;
      off_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      div_q      <= div_d;
      off_q      <= off_d;
      rd_valid_q <= rd_valid_d;
      // The read samples the array before this edge's write lands, so a
      // same-entry collision returns the old value.
      if (rd_valid_d) rd_data_q <= mem_q[rd_phys];
    end
  end

  // NOTE: the storage array has no reset. The INIT sweep rewrites every entry
  // after each reset, so resetting the array would only add logic.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_INIT);
  assign offset   = off_q;

endmodule

// File: tb/tb_palette_cycler.sv
// -----------------------------------------------------------------------------
// tb_palette_cycler
//   Directed scoreboard bench for palette_cycler (default parameters 24/4/8).
//   The stimulus pushes the expected read data when it issues a read. A monitor
//   on the falling edge pops and compares on every rd_valid. Status outputs
//   (busy, offset, rd_valid) are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_palette_cycler;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic        frame_tick;
  logic        cycle_en;
  logic        cycle_dir;
  logic [7:0]  cycle_div;
  logic        busy;
  logic [3:0]  offset;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q [$];

  palette_cycler #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .DIV_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_tick (frame_tick),
    .cycle_en   (cycle_en),
    .cycle_dir  (cycle_dir),
    .cycle_div  (cycle_div),
    .busy       (busy),
    .offset     (offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every valid read result must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 data=%06h, required rd_valid=0", rd_data);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %06h, required %06h", rd_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input logic [3:0] idx, input logic [23:0] exp);
    rd_en   = 1'b1;
    rd_addr = idx;
    exp_q.push_back(exp);
    step();
    rd_en   = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; frame_tick = 1'b0;
    cycle_en = 1'b0; cycle_dir = 1'b0; cycle_div = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_busy", busy, 1);
    check("reset_offset", offset, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    repeat (2) step();
    rst = 1'b0;

    // INIT: a read held high the whole time must be dropped.
    rd_en = 1'b1; rd_addr = 4'd5;
    repeat (15) step();
    check("init_busy_edge15", busy, 1);
    check("init_rd_dropped", rd_valid, 0);
    step();
    check("init_busy_edge16", busy, 0);
    rd_en = 1'b0;
    check("init_last_rd_dropped", rd_valid, 0);

    // Default ramp, back-to-back reads at offset 0.
    for (int i = 0; i < 16; i++) read(4'(i), 24'h111111 * 24'(i));
    drain();

    // Write then read; then a same-cycle collision returns the old value.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 24'hCC0000;
    step();
    wr_en = 1'b0;
    read(4'd3, 24'hCC0000);
    wr_en = 1'b1; wr_data = 24'h00CC00;
    read(4'd3, 24'hCC0000);
    wr_en = 1'b0;
    read(4'd3, 24'h00CC00);
    drain();

    // Increment every third tick.
    cycle_en = 1'b1; cycle_div = 8'd2; cycle_dir = 1'b0;
    tick(); tick();
    check("rot_tick2", offset, 0);
    tick();
    check("rot_tick3", offset, 1);
    tick(); tick(); tick();
    check("rot_tick6", offset, 2);
    tick(); tick(); tick();
    check("rot_tick9", offset, 3);
    read(4'd0, 24'h00CC00);
    drain();

    // Decrement every tick, wrapping 0 -> 15.
    cycle_dir = 1'b1; cycle_div = 8'd0;
    tick(); tick(); tick();
    check("dec_to_zero", offset, 0);
    tick();
    check("dec_wrap", offset, 15);
    read(4'd1, 24'h000000);
    drain();

    // Increment wraps 15 -> 0 -> 1, then a read during the rotating tick.
    cycle_dir = 1'b0;
    tick();
    check("inc_wrap", offset, 0);
    tick();
    check("inc_to_one", offset, 1);
    frame_tick = 1'b1; rd_en = 1'b1; rd_addr = 4'd4;
    exp_q.push_back(24'h555555);
    step();
    frame_tick = 1'b0; rd_en = 1'b0;
    step();
    check("tick_read_offset", offset, 2);
    read(4'd4, 24'h666666);
    drain();

    // cycle_div lowered below the count: the next tick is terminal.
    cycle_div = 8'd3;
    tick(); tick();
    check("div3_two_ticks", offset, 2);
    cycle_div = 8'd1;
    tick();
    check("div_lowered", offset, 3);
    // cycle_en low: ticks do not change anything.
    cycle_en = 1'b0; cycle_div = 8'd0;
    tick(); tick();
    check("cycle_disabled_hold", offset, 3);

    // Mid-operation reset: async return, INIT reruns, writes dropped in INIT.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 24'hABCDEF;
    step();
    wr_addr = 4'd3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 1);
    check("async_rst_offset", offset, 0);
    check("async_rst_rd_valid", rd_valid, 0);
    step();
    rst = 1'b0;
    repeat (15) step();
    check("reinit_busy_edge15", busy, 1);
    step();
    check("reinit_busy_edge16", busy, 0);
    wr_en = 1'b0;
    check("reinit_offset", offset, 0);
    read(4'd3, 24'h333333);
    read(4'd7, 24'h777777);
    read(4'd0, 24'h000000);
    drain();
    step();
    check("idle_rd_valid", rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
